// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: LSL / LSR / ASR / ROR, one power-of-two shift per
// register stage, valid/ready on both sides with full backpressure.
// Optional carry output: define PIPELINED_BARREL_SHIFTER_CARRY_EN to add down_carry.

// One pipeline slot: applies a 2^K shift when amt bit K is set.
module pbs_stage #(
  parameter  int N   = 8,
  parameter  int K   = 0,
  localparam int A_W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           in_valid,
  input  logic [N-1:0]   in_data,
  input  logic [A_W-1:0] in_amt,
  input  logic [1:0]     in_op,
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
  input  logic           in_carry,
  output logic           out_carry,
`endif
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [A_W-1:0] out_amt,
  output logic [1:0]     out_op
);
  localparam int S = 1 << K;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic           valid_q;
  logic [N-1:0]   data_q, data_d;
  logic [A_W-1:0] amt_q;
  logic [1:0]     op_q;

  // Shift network for this stage; ASR refills with the current MSB, which
  // earlier ASR stages have kept equal to the original sign.
  always_comb begin
    data_d = in_data;
    if (in_amt[K]) begin
      unique case (in_op)
        OP_LSL: data_d = in_data << S;
        OP_LSR: data_d = in_data >> S;
        OP_ASR: data_d = N'($signed(in_data) >>> S);
        OP_ROR: data_d = (in_data >> S) | (in_data << (N - S));
      endcase
    end
  end

  // Slot occupancy: advance whenever this slot is free or drains this cycle.
  always_ff @(posedge clk) begin
    if (rst)     valid_q <= 1'b0;
    else if (ld) valid_q <= in_valid;
  end

  // Payload is only captured on a real transfer; it is don't-care otherwise.
  always_ff @(posedge clk) begin
    if (ld && in_valid) begin
      data_q <= data_d;
      amt_q  <= in_amt;
      op_q   <= in_op;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_op    = op_q;

`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
  logic carry_q, carry_d;

  // Carry is the last bit pushed out by the final active stage; for ROR that
  // is the bit that lands in the MSB. Inactive stages forward it untouched.
  always_comb begin
    carry_d = in_carry;
    if (in_amt[K]) begin
      unique case (in_op)
        OP_LSL:  carry_d = in_data[N-S];
        default: carry_d = in_data[S-1];
      endcase
    end
  end

  // Carry travels with the data; cleared on reset so down_carry reads 0.
  always_ff @(posedge clk) begin
    if (rst)                 carry_q <= 1'b0;
    else if (ld && in_valid) carry_q <= carry_d;
  end

  assign out_carry = carry_q;
`endif
endmodule

module pipelined_barrel_shifter #(
  parameter  int N      = 8,
  localparam int A_W    = $clog2(N),
  localparam int STAGES = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up_valid,
  output logic           up_ready,
  input  logic [N-1:0]   up_data,
  input  logic [A_W-1:0] up_amt,
  input  logic [1:0]     up_op,
  output logic           down_valid,
  input  logic           down_ready,
  output logic [N-1:0]   down_data
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
  ,
  output logic           down_carry
`endif
);
  // Index 0 is the upstream port, index k+1 is the output of stage k.
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0]          rdy;
  logic [STAGES:0][N-1:0]   data_pipe;
  logic [STAGES:0][A_W-1:0] amt_pipe;
  logic [STAGES:0][1:0]     op_pipe;

  assign vld_pipe[0]  = up_valid;
  assign data_pipe[0] = up_data;
  assign amt_pipe[0]  = up_amt;
  assign op_pipe[0]   = up_op;

  // Ready ripples back from the consumer; an empty slot is always ready, so
  // bubbles collapse even while the output is stalled.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = down_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      rdy[k] = !vld_pipe[k+1] || rdy[k+1];
  end

`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
  logic [STAGES:0] cry_pipe;
  assign cry_pipe[0] = 1'b0;
  assign down_carry  = cry_pipe[STAGES];
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pbs_stage #(.N(N), .K(k)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ld        (rdy[k]),
      .in_valid  (vld_pipe[k]),
      .in_data   (data_pipe[k]),
      .in_amt    (amt_pipe[k]),
      .in_op     (op_pipe[k]),
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
      .in_carry  (cry_pipe[k]),
      .out_carry (cry_pipe[k+1]),
`endif
      .out_valid (vld_pipe[k+1]),
      .out_data  (data_pipe[k+1]),
      .out_amt   (amt_pipe[k+1]),
      .out_op    (op_pipe[k+1])
    );
  end

  // The last stage's amount and op have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_pipe[STAGES], op_pipe[STAGES]};

  // Reset flushes every slot, so the input is reported ready while it is held.
  assign up_ready   = rdy[0] | rst;
  assign down_valid = vld_pipe[STAGES];
  assign down_data  = data_pipe[STAGES];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (N=8): directed table, backpressure
// stream, mid-flight reset and randomized traffic against a reference model.
module tb_pipelined_barrel_shifter;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid, up_ready;
  logic [7:0] up_data;
  logic [2:0] up_amt;
  logic [1:0] up_op;
  logic       down_valid, down_ready;
  logic [7:0] down_data;
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
  logic       down_carry;
`endif

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amt     (up_amt),
    .up_op      (up_op),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
    ,
    .down_carry (down_carry)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic [1:0] op;
    logic [7:0] exp_d;
    logic       exp_c;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       c;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the operation definitions.
  function automatic res_t ref_model(input logic [7:0] a, input int amt, input logic [1:0] op);
    res_t r;
    logic signed [7:0] sa;
    logic [15:0] w;
    sa = a;
    w  = {a, a} >> amt;
    case (op)
      2'd0:    r.d = a << amt;
      2'd1:    r.d = a >> amt;
      2'd2:    r.d = sa >>> amt;
      default: r.d = w[7:0];
    endcase
    if (amt == 0)        r.c = 1'b0;
    else if (op == 2'd0) r.c = a[N-amt];
    else if (op == 2'd3) r.c = r.d[N-1];
    else                 r.c = a[amt-1];
    return r;
  endfunction

  vec_t tbl[12];
  res_t eq[$];
  res_t er;
  int   sent, got, stall;
  logic saw_full;

  initial begin
    tbl[0]  = '{8'hB6, 3'd3, 2'd0, 8'hB0, 1'b1};
    tbl[1]  = '{8'hB6, 3'd3, 2'd1, 8'h16, 1'b1};
    tbl[2]  = '{8'hB6, 3'd3, 2'd2, 8'hF6, 1'b1};
    tbl[3]  = '{8'hB6, 3'd3, 2'd3, 8'hD6, 1'b1};
    tbl[4]  = '{8'h5A, 3'd0, 2'd0, 8'h5A, 1'b0};
    tbl[5]  = '{8'h5A, 3'd0, 2'd1, 8'h5A, 1'b0};
    tbl[6]  = '{8'h5A, 3'd0, 2'd2, 8'h5A, 1'b0};
    tbl[7]  = '{8'h5A, 3'd0, 2'd3, 8'h5A, 1'b0};
    tbl[8]  = '{8'h81, 3'd7, 2'd0, 8'h80, 1'b0};
    tbl[9]  = '{8'h81, 3'd7, 2'd1, 8'h01, 1'b0};
    tbl[10] = '{8'h81, 3'd7, 2'd2, 8'hFF, 1'b0};
    tbl[11] = '{8'h81, 3'd7, 2'd3, 8'h03, 1'b0};

    // Reset
    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_amt = '0; up_op = '0; down_ready = 1'b0;
    tick();
    chk("rst_up_ready", up_ready, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_down_valid", down_valid, 0);
    chk("rst_up_ready_after", up_ready, 1);
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
    chk("rst_carry", down_carry, 0);
`endif
    tick();

    // Idle pipeline
    for (int i = 0; i < 10; i++) begin
      chk("idle_down_valid", down_valid, 0);
      chk("idle_up_ready", up_ready, 1);
      tick();
    end

    // Directed table, back to back, exact latency of 3
    down_ready = 1'b1;
    for (int cyc = 0; cyc < 12 + 3; cyc++) begin
      if (cyc < 12) begin
        up_valid = 1'b1; up_data = tbl[cyc].a; up_amt = tbl[cyc].amt; up_op = tbl[cyc].op;
      end else begin
        up_valid = 1'b0;
      end
      #1;
      if (cyc < 12) chk("tbl_up_ready", up_ready, 1);
      if (cyc >= 3) begin
        chk("tbl_valid", down_valid, 1);
        chk("tbl_data", down_data, tbl[cyc-3].exp_d);
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
        chk("tbl_carry", down_carry, tbl[cyc-3].exp_c);
`endif
      end else begin
        chk("tbl_latency", down_valid, 0);
      end
      tick();
    end
    up_valid = 1'b0;
    #1;
    chk("tbl_drained", down_valid, 0);
    tick();

    // Backpressure stream: 10 operands, LSL by 1, 5-cycle stall after first result
    sent = 0; got = 0; stall = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      down_ready = (stall == 0);
      if (stall > 0) stall--;
      up_valid = (sent < 10); up_data = 8'(sent + 1); up_amt = 3'd1; up_op = 2'd0;
      #1;
      chk("bp_up_ready", up_ready, !((sent - got) == 3 && !down_ready));
      if (!up_ready) saw_full = 1'b1;
      if (down_valid) begin
        chk("bp_data", down_data, 2 * (got + 1));
        if (down_ready) begin
          got++;
          if (got == 1) stall = 5;
        end
      end
      if (up_valid && up_ready) sent++;
      tick();
    end
    up_valid = 1'b0; down_ready = 1'b1;
    #1;
    chk("bp_sent", sent, 10);
    chk("bp_got", got, 10);
    chk("bp_up_ready_dropped", saw_full, 1);
    chk("bp_no_dup", down_valid, 0);
    tick();

    // Reset with three transactions in flight
    down_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = 8'(8'h11 * (i + 1)); up_amt = 3'd2; up_op = 2'd1;
      #1;
      chk("mrst_fill_ready", up_ready, 1);
      tick();
    end
    up_valid = 1'b0;
    #1;
    chk("mrst_full_valid", down_valid, 1);
    chk("mrst_full_ready", up_ready, 0);
    rst = 1'b1;
    #1;
    chk("mrst_up_ready_in_rst", up_ready, 1);
    tick();
    rst = 1'b0;
    down_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("mrst_down_valid", down_valid, 0);
      chk("mrst_up_ready", up_ready, 1);
      tick();
    end

    // Randomized traffic against the model
    sent = 0; got = 0;
    eq.delete();
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      up_valid   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      up_data    = 8'($urandom);
      up_amt     = 3'($urandom);
      up_op      = 2'($urandom);
      down_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (down_valid && down_ready) begin
        if (eq.size() == 0) begin
          n_chk++;
          $display("FAIL rnd_extra: got unexpected result %0h expected none", down_data);
        end else begin
          er = eq.pop_front();
          chk("rnd_data", down_data, er.d);
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
          chk("rnd_carry", down_carry, er.c);
`endif
          got++;
        end
      end
      if (up_valid && up_ready) begin
        eq.push_back(ref_model(up_data, int'(up_amt), up_op));
        sent++;
      end
      tick();
    end
    chk("rnd_count_in", sent, 1000);
    chk("rnd_count_out", got, 1000);
    chk("rnd_queue_empty", eq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
